// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blink sequencer and its duration counter.
package blink_pkg;

  localparam int COUNT_LENGTH_DEF = 3;
  localparam int BLINK_W_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } blink_state_e;

  // A zero-length phase would never see a counter timeout, so stretch it to one tick.
  function automatic int unsigned clamp_ticks(input int unsigned ticks);
    return (ticks == 0) ? 1 : ticks;
  endfunction

endpackage

// File: rtl/blink_sequencer_counter.sv
// Phase duration counter: counts 0..i_val-1 while enabled and flags the last tick.
module blink_sequencer_counter #(
  parameter int COUNT_LENGTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [COUNT_LENGTH-1:0] i_val,
  output logic                    o_timeout
);

  logic [COUNT_LENGTH-1:0] count_q;

  assign o_timeout = i_en && (count_q == (i_val - COUNT_LENGTH'(1)));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (!i_en || o_timeout) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + COUNT_LENGTH'(1);
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// Drives one LED through a programmed burst of on/off blinks with a start/busy/done handshake.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int COUNT_LENGTH = COUNT_LENGTH_DEF,
  parameter int BLINK_W      = BLINK_W_DEF,
  parameter bit LED_POL      = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [BLINK_W-1:0]      i_blinks,
  input  logic [COUNT_LENGTH-1:0] i_on_ticks,
  input  logic [COUNT_LENGTH-1:0] i_off_ticks,
  output logic                    o_led,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BLINK_W-1:0]      o_remaining
);

  blink_state_e            state_q, state_d;
  logic [COUNT_LENGTH-1:0] on_q, off_q;
  logic [BLINK_W-1:0]      remaining_q;
  logic                    cnt_en;
  logic [COUNT_LENGTH-1:0] cnt_val;
  logic                    cnt_timeout;
  logic                    accept;
  logic                    led_on;

  assign accept  = (state_q == ST_IDLE) && i_start && (i_blinks != '0);
  assign cnt_en  = (state_q == ST_ON) || (state_q == ST_OFF);
  assign cnt_val = (state_q == ST_OFF) ? off_q : on_q;

  blink_sequencer_counter #(
    .COUNT_LENGTH(COUNT_LENGTH)
  ) u_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (cnt_en),
    .i_val    (cnt_val),
    .o_timeout(cnt_timeout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = (i_blinks != '0) ? ST_ON : ST_DONE;
        end
      end
      ST_ON: begin
        if (cnt_timeout) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (cnt_timeout) begin
          state_d = (remaining_q == BLINK_W'(1)) ? ST_DONE : ST_ON;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Config is captured only on an accepted start; later input changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      on_q  <= '0;
      off_q <= '0;
    end else if (accept) begin
      on_q  <= COUNT_LENGTH'(clamp_ticks(32'(i_on_ticks)));
      off_q <= COUNT_LENGTH'(clamp_ticks(32'(i_off_ticks)));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining_q <= '0;
    end else if (accept) begin
      remaining_q <= i_blinks;
    end else if ((state_q == ST_OFF) && cnt_timeout) begin
      remaining_q <= remaining_q - BLINK_W'(1);
    end
  end

  assign led_on      = (state_q == ST_ON);
  assign o_led       = LED_POL ? led_on : ~led_on;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_remaining = remaining_q;

endmodule
